// File: rtl/ras_rt_ptr_track_pkg.sv
// ras_rt_ptr_track_pkg
// Core RAS definitions shared by the fetch return address stack and the
// retire-side pointer tracker: action encodings, pointer width and the
// pointer-update function used on both sides.
package ras_rt_ptr_track_pkg;

    // RAS pointer width (16-entry return address stack)
    localparam int RAS_PTR_W = 4;

    // RAS action encodings carried with every call/return checkpoint
    localparam logic [1:0] RAS_NOAC = 2'b00;  // no stack action
    localparam logic [1:0] RAS_PUSH = 2'b01;  // call
    localparam logic [1:0] RAS_POP  = 2'b10;  // return
    localparam logic [1:0] RAS_POPU = 2'b11;  // pop-then-push, pointer unchanged

    typedef logic [1:0]           ras_ctl_t;
    typedef logic [RAS_PTR_W-1:0] ras_ptr_t;

    // Top-of-stack pointer after applying one RAS action; wraps modulo 2^RAS_PTR_W
    function automatic ras_ptr_t ras_apply_ptr(input ras_ptr_t ptr, input ras_ctl_t ctl);
        ras_ptr_t res;
        case (ctl)
            RAS_PUSH: res = ptr + {{(RAS_PTR_W-1){1'b0}}, 1'b1};
            RAS_POP:  res = ptr - {{(RAS_PTR_W-1){1'b0}}, 1'b1};
            RAS_NOAC: res = ptr;
            RAS_POPU: res = ptr;
            default:  res = ptr;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/ras_rt_ptr_track_ckpt_fifo.sv
// ras_ckpt_fifo
// In-order checkpoint storage for RAS-affecting branches: entry arrays plus
// head/tail/count bookkeeping. 'clear' is a synchronous clear used on a
// retire flush; it discards every outstanding entry at the next edge.
// Callers present already-qualified write/read enables.
// Optional feature macro: RAS_RT_CHECK_EN keeps the predicted pointer per
// entry so the top level can cross-check it at retire time.
import ras_rt_ptr_track_pkg::*;

module ras_ckpt_fifo #(
    parameter int DEPTH = 8,
    parameter int IDX_W = 3,
    parameter int PTR_W = RAS_PTR_W
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             wr_en,
    input  logic [1:0]       wr_ctl,
`ifdef RAS_RT_CHECK_EN
    input  logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] rd_ptr,
`endif
    input  logic             rd_en,
    output logic [1:0]       rd_ctl,
    output logic [IDX_W-1:0] tail,
    output logic [IDX_W:0]   count
);

    logic [IDX_W-1:0] head_r;
    logic [IDX_W-1:0] tail_r;
    logic [IDX_W:0]   count_r;
    logic [1:0]       ctl_mem_r [DEPTH];
`ifdef RAS_RT_CHECK_EN
    logic [PTR_W-1:0] ptr_mem_r [DEPTH];
`endif

    // Head/tail/count bookkeeping; flush clear wins over a same-cycle write
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_r  <= {IDX_W{1'b0}};
            tail_r  <= {IDX_W{1'b0}};
            count_r <= {(IDX_W+1){1'b0}};
        end else if (clear) begin
            head_r  <= {IDX_W{1'b0}};
            tail_r  <= {IDX_W{1'b0}};
            count_r <= {(IDX_W+1){1'b0}};
        end else begin
            if (wr_en) begin
                tail_r <= tail_r + {{(IDX_W-1){1'b0}}, 1'b1};
            end else begin
                tail_r <= tail_r;
            end
            if (rd_en) begin
                head_r <= head_r + {{(IDX_W-1){1'b0}}, 1'b1};
            end else begin
                head_r <= head_r;
            end
            case ({wr_en, rd_en})
                2'b10:   count_r <= count_r + {{IDX_W{1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{IDX_W{1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

    // Checkpoint action storage, written at the tail slot on an accepted allocation
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ctl_mem_r[i] <= RAS_NOAC;
            end
        end else if (wr_en && !clear) begin
            ctl_mem_r[tail_r] <= wr_ctl;
        end else begin
            ctl_mem_r <= ctl_mem_r;
        end
    end

`ifdef RAS_RT_CHECK_EN
    // Predicted-pointer storage, kept only for the retire cross-check
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ptr_mem_r[i] <= {PTR_W{1'b0}};
            end
        end else if (wr_en && !clear) begin
            ptr_mem_r[tail_r] <= wr_ptr;
        end else begin
            ptr_mem_r <= ptr_mem_r;
        end
    end

    assign rd_ptr = ptr_mem_r[head_r];
`endif

    assign rd_ctl = ctl_mem_r[head_r];
    assign tail   = tail_r;
    assign count  = count_r;

endmodule

// File: rtl/ras_rt_ptr_track.sv
// ras_rt_ptr_track
// Retire-side tracker for the fetch return address stack. Records one
// checkpoint per fetched call/return, retires them in order, keeps the
// committed RAS top-of-stack pointer and presents the recovery pointer that
// fetch uses on a retire flush. The recovery pointer already includes a
// retire accepted in the same cycle, so retire+flush recovers correctly.
// Optional feature macro: RAS_RT_CHECK_EN adds the sticky ras_mismatch_o
// output comparing predicted against resolved RAS behaviour at retire.
import ras_rt_ptr_track_pkg::*;

module ras_rt_ptr_track #(
    parameter int DEPTH = 8,
    parameter int IDX_W = 3,
    parameter int PTR_W = RAS_PTR_W
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             alloc_vld_i,
    input  logic [1:0]       alloc_rasctl_i,
    input  logic [PTR_W-1:0] alloc_ptr_i,
    output logic             alloc_rdy_o,
    output logic [IDX_W-1:0] alloc_id_o,
    input  logic             rt_vld_i,
    input  logic [1:0]       rt_rasctl_i,
    input  logic             flush_rt_i,
    output logic [PTR_W-1:0] ras_ptr_rt_o,
    output logic             bob_vld_o,
`ifdef RAS_RT_CHECK_EN
    output logic             ras_mismatch_o,
`endif
    output logic [IDX_W:0]   count_o
);

    localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(DEPTH);

    logic [PTR_W-1:0] arch_ptr_r;
    logic [PTR_W-1:0] arch_ptr_nxt_s;
    logic [PTR_W-1:0] rt_applied_s;
    logic             alloc_acc_s;
    logic             rt_acc_s;
    logic             not_full_s;
    logic             not_empty_s;
    logic [IDX_W-1:0] tail_s;
    logic [IDX_W:0]   count_s;
    logic [1:0]       head_ctl_s;
`ifdef RAS_RT_CHECK_EN
    logic [PTR_W-1:0] head_ptr_s;
    logic             mismatch_r;
    logic             mismatch_hit_s;
`else
    logic             unused_chk_s;
`endif

    // Handshake qualification and committed-pointer next value
    always_comb begin
        not_full_s     = (count_s != FULL_CNT);
        not_empty_s    = (count_s != {(IDX_W+1){1'b0}});
        alloc_acc_s    = alloc_vld_i & not_full_s & ~flush_rt_i;
        rt_acc_s       = rt_vld_i & not_empty_s;
        rt_applied_s   = ras_apply_ptr(arch_ptr_r, rt_rasctl_i);
        arch_ptr_nxt_s = arch_ptr_r;
        if (rt_acc_s) begin
            arch_ptr_nxt_s = rt_applied_s;
        end else begin
            arch_ptr_nxt_s = arch_ptr_r;
        end
    end

    // Committed RAS pointer; a flush does not touch it, only retires move it
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            arch_ptr_r <= {PTR_W{1'b0}};
        end else begin
            arch_ptr_r <= arch_ptr_nxt_s;
        end
    end

    ras_ckpt_fifo #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W),
        .PTR_W (PTR_W)
    ) u_ckpt_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (flush_rt_i),
        .wr_en   (alloc_acc_s),
        .wr_ctl  (alloc_rasctl_i),
`ifdef RAS_RT_CHECK_EN
        .wr_ptr  (alloc_ptr_i),
        .rd_ptr  (head_ptr_s),
`endif
        .rd_en   (rt_acc_s),
        .rd_ctl  (head_ctl_s),
        .tail    (tail_s),
        .count   (count_s)
    );

`ifdef RAS_RT_CHECK_EN
    // Predicted vs resolved comparison for the retiring checkpoint
    always_comb begin
        mismatch_hit_s = 1'b0;
        if (rt_acc_s) begin
            mismatch_hit_s = (head_ptr_s != rt_applied_s) | (head_ctl_s != rt_rasctl_i);
        end else begin
            mismatch_hit_s = 1'b0;
        end
    end

    // Sticky mismatch flag; only reset clears it, flush leaves it set
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mismatch_r <= 1'b0;
        end else if (mismatch_hit_s) begin
            mismatch_r <= 1'b1;
        end else begin
            mismatch_r <= mismatch_r;
        end
    end

    assign ras_mismatch_o = mismatch_r;
`else
    // Predicted pointer and stored action are not consumed without the cross-check
    assign unused_chk_s = ^{alloc_ptr_i, head_ctl_s};
`endif

    assign alloc_rdy_o  = not_full_s;
    assign alloc_id_o   = tail_s;
    assign bob_vld_o    = not_empty_s;
    assign count_o      = count_s;
    assign ras_ptr_rt_o = arch_ptr_nxt_s;

endmodule

// File: tb/tb_ras_rt_ptr_track.sv
// tb_ras_rt_ptr_track
// Directed self-checking bench for ras_rt_ptr_track with hand-computed
// expected values. Inputs change 1 time unit after the rising edge; all
// outputs are sampled there too, well clear of the active edge.
// With RAS_RT_CHECK_EN defined the sticky mismatch flag is also exercised.
`timescale 1ns/1ps

module tb_ras_rt_ptr_track;

    logic       clock;
    logic       reset_n;
    logic       alloc_vld_i;
    logic [1:0] alloc_rasctl_i;
    logic [3:0] alloc_ptr_i;
    logic       alloc_rdy_o;
    logic [2:0] alloc_id_o;
    logic       rt_vld_i;
    logic [1:0] rt_rasctl_i;
    logic       flush_rt_i;
    logic [3:0] ras_ptr_rt_o;
    logic       bob_vld_o;
    logic [3:0] count_o;
`ifdef RAS_RT_CHECK_EN
    logic       ras_mismatch_o;
`endif

    int n_checks = 0;
    int n_errors = 0;

    ras_rt_ptr_track dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .alloc_vld_i    (alloc_vld_i),
        .alloc_rasctl_i (alloc_rasctl_i),
        .alloc_ptr_i    (alloc_ptr_i),
        .alloc_rdy_o    (alloc_rdy_o),
        .alloc_id_o     (alloc_id_o),
        .rt_vld_i       (rt_vld_i),
        .rt_rasctl_i    (rt_rasctl_i),
        .flush_rt_i     (flush_rt_i),
        .ras_ptr_rt_o   (ras_ptr_rt_o),
        .bob_vld_o      (bob_vld_o),
`ifdef RAS_RT_CHECK_EN
        .ras_mismatch_o (ras_mismatch_o),
`endif
        .count_o        (count_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [1:0] actl, input logic [3:0] aptr,
                         input logic rv, input logic [1:0] rctl, input logic fl);
        alloc_vld_i    = av;
        alloc_rasctl_i = actl;
        alloc_ptr_i    = aptr;
        rt_vld_i       = rv;
        rt_rasctl_i    = rctl;
        flush_rt_i     = fl;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 2'b00, 4'd0, 1'b0, 2'b00, 1'b0);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // one allocation cycle
    task automatic alloc1(input logic [1:0] ctl, input logic [3:0] ptr);
        drive(1'b1, ctl, ptr, 1'b0, 2'b00, 1'b0);
        tick();
    endtask

    // one retire cycle, checking the same-cycle recovery pointer first
    task automatic retire1(input logic [1:0] ctl, input logic [3:0] exp_ptr, input string tag);
        drive(1'b0, 2'b00, 4'd0, 1'b1, ctl, 1'b0);
        check_val(tag, 32'(ras_ptr_rt_o), 32'(exp_ptr));
        tick();
    endtask

    initial begin
        reset_n = 1'b0;
        idle();
        #10;
        check_val("rst_rdy",   32'(alloc_rdy_o),  32'd1);
        check_val("rst_id",    32'(alloc_id_o),   32'd0);
        check_val("rst_bob",   32'(bob_vld_o),    32'd0);
        check_val("rst_count", 32'(count_o),      32'd0);
        check_val("rst_ptr",   32'(ras_ptr_rt_o), 32'd0);
`ifdef RAS_RT_CHECK_EN
        check_val("rst_mis",   32'(ras_mismatch_o), 32'd0);
`endif
        reset_n = 1'b1;
        tick();

        // 1: push,push,pop allocated then retired -> 0,1,2,1
        alloc1(2'b01, 4'd1);
        alloc1(2'b01, 4'd2);
        alloc1(2'b10, 4'd1);
        idle();
        check_val("t1_count3", 32'(count_o),   32'd3);
        check_val("t1_bob1",   32'(bob_vld_o), 32'd1);
        check_val("t1_id3",    32'(alloc_id_o), 32'd3);
        retire1(2'b01, 4'd1, "t1_rt_push1");
        retire1(2'b01, 4'd2, "t1_rt_push2");
        retire1(2'b10, 4'd1, "t1_rt_pop");
        idle();
        check_val("t1_count0", 32'(count_o),      32'd0);
        check_val("t1_bob0",   32'(bob_vld_o),    32'd0);
        check_val("t1_arch",   32'(ras_ptr_rt_o), 32'd1);

        // 2: fill to 8, refuse a 9th even with a same-cycle retire
        for (int i = 0; i < 8; i++) begin
            alloc1(2'b00, 4'd1);
        end
        idle();
        check_val("t2_count8", 32'(count_o),     32'd8);
        check_val("t2_rdy0",   32'(alloc_rdy_o), 32'd0);
        check_val("t2_id_wrap", 32'(alloc_id_o), 32'd3);
        drive(1'b1, 2'b01, 4'd2, 1'b1, 2'b00, 1'b0);
        tick();
        idle();
        check_val("t2_count7", 32'(count_o),     32'd7);
        check_val("t2_id_same", 32'(alloc_id_o), 32'd3);
        check_val("t2_rdy1",   32'(alloc_rdy_o), 32'd1);
        for (int i = 0; i < 7; i++) begin
            retire1(2'b00, 4'd1, "t2_drain");
        end
        idle();
        check_val("t2_empty", 32'(count_o), 32'd0);

        // 3: walk arch_ptr to 15, then wrap 15->0 and back 0->15
        alloc1(2'b10, 4'd0);
        alloc1(2'b10, 4'd15);
        alloc1(2'b01, 4'd0);
        alloc1(2'b10, 4'd15);
        retire1(2'b10, 4'd0,  "t3_pop_to0");
        retire1(2'b10, 4'd15, "t3_pop_to15");
        retire1(2'b01, 4'd0,  "t3_wrap_up");
        idle();
        check_val("t3_arch0", 32'(ras_ptr_rt_o), 32'd0);
        retire1(2'b10, 4'd15, "t3_wrap_dn");
        idle();
        check_val("t3_arch15", 32'(ras_ptr_rt_o), 32'd15);

        // 4: walk to 4, five outstanding, retire pop + flush + alloc same cycle
        for (int i = 0; i < 5; i++) begin
            alloc1(2'b01, 4'(i));
        end
        for (int i = 0; i < 5; i++) begin
            retire1(2'b01, 4'(i), "t4_walk");
        end
        alloc1(2'b10, 4'd3);
        for (int i = 0; i < 4; i++) begin
            alloc1(2'b00, 4'd3);
        end
        idle();
        check_val("t4_count5", 32'(count_o), 32'd5);
        drive(1'b1, 2'b01, 4'd4, 1'b1, 2'b10, 1'b1);
        check_val("t4_flush_ptr", 32'(ras_ptr_rt_o), 32'd3);
        check_val("t4_flush_bob", 32'(bob_vld_o),    32'd1);
        tick();
        idle();
        check_val("t4_count0", 32'(count_o),      32'd0);
        check_val("t4_bob0",   32'(bob_vld_o),    32'd0);
        check_val("t4_id0",    32'(alloc_id_o),   32'd0);
        check_val("t4_arch3",  32'(ras_ptr_rt_o), 32'd3);

        // 5: retire while empty is ignored
        drive(1'b0, 2'b00, 4'd0, 1'b1, 2'b01, 1'b0);
        check_val("t5_comb_ptr", 32'(ras_ptr_rt_o), 32'd3);
        tick();
        idle();
        check_val("t5_arch", 32'(ras_ptr_rt_o), 32'd3);
        check_val("t5_count", 32'(count_o),     32'd0);
`ifdef RAS_RT_CHECK_EN
        check_val("t5_no_mis", 32'(ras_mismatch_o), 32'd0);
`endif

        // asynchronous reset with entries outstanding clears without an edge
        alloc1(2'b00, 4'd3);
        alloc1(2'b00, 4'd3);
        idle();
        check_val("ar_count2", 32'(count_o), 32'd2);
        #2;
        reset_n = 1'b0;
        #1;
        check_val("ar_count0", 32'(count_o),      32'd0);
        check_val("ar_ptr0",   32'(ras_ptr_rt_o), 32'd0);
        #3;
        reset_n = 1'b1;
        tick();

`ifdef RAS_RT_CHECK_EN
        // 6: mispredicted pointer sets the sticky flag, survives flush, cleared by reset
        alloc1(2'b01, 4'd1);
        alloc1(2'b01, 4'd2);
        retire1(2'b01, 4'd1, "t6_walk1");
        retire1(2'b01, 4'd2, "t6_walk2");
        idle();
        check_val("t6_mis0", 32'(ras_mismatch_o), 32'd0);
        alloc1(2'b01, 4'd5);
        retire1(2'b01, 4'd3, "t6_rt");
        idle();
        check_val("t6_mis1", 32'(ras_mismatch_o), 32'd1);
        drive(1'b0, 2'b00, 4'd0, 1'b0, 2'b00, 1'b1);
        tick();
        idle();
        check_val("t6_mis_flush", 32'(ras_mismatch_o), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_val("t6_mis_rst", 32'(ras_mismatch_o), 32'd0);
        #3;
        reset_n = 1'b1;
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
